// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack sequencer: operator codes, error codes and controller states.
package rpn_pkg;

   localparam int unsigned OP_FIELD_W = 3;

   typedef enum logic [OP_FIELD_W-1:0] {
      OpAdd  = 3'd0,
      OpSub  = 3'd1,
      OpMul  = 3'd2,
      OpAnd  = 3'd3,
      OpOr   = 3'd4,
      OpXor  = 3'd5,
      OpDup  = 3'd6,
      OpEmit = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ErrNone  = 2'b00,
      ErrUnder = 2'b01,
      ErrOver  = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      StIdle,
      StReplace,
      StEmit
   } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for binary RPN operators; a is the lower element, b the former top.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  op_e                   op,
   output logic [DATA_WIDTH-1:0] y
);

   logic [2*DATA_WIDTH-1:0] prod;

   assign prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

   always_comb begin
      y = '0;
      unique case (op)
         OpAdd:  y = a + b;
         OpSub:  y = a - b;
         OpMul:  y = prod[DATA_WIDTH-1:0];
         OpAnd:  y = a & b;
         OpOr:   y = a | b;
         OpXor:  y = a ^ b;
         // Never latched as a pending binary op.
         OpDup:  y = b;
         OpEmit: y = b;
      endcase
   end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN token sequencer driving an external LIFO; a shadow depth count rejects
// underflow/overflow tokens before the stack is touched.
module rpn_stack_ctrl
   import rpn_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned LIFO_SIZE  = 20,
   localparam int unsigned DEPTH_W    = $clog2(LIFO_SIZE + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tok_valid,
   output logic                  tok_ready,
   input  logic                  tok_is_op,
   input  logic [DATA_WIDTH-1:0] tok_data,
   output logic [DATA_WIDTH-1:0] stk_entry,
   output logic                  stk_insert,
   output logic                  stk_pop,
   input  logic [DATA_WIDTH-1:0] stk_top,
   input  logic                  stk_full,
   input  logic                  stk_empty,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  err_valid,
   output logic [1:0]            err_code,
   output logic [DEPTH_W-1:0]    depth
);

   localparam logic [DEPTH_W-1:0] FULL_CNT = DEPTH_W'(LIFO_SIZE);
   localparam logic [DEPTH_W-1:0] ONE      = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] TWO      = DEPTH_W'(2);

   state_e                  state_q, state_d;
   logic [DEPTH_W-1:0]      depth_q, depth_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   op_e                     op_q, op_d;
   logic                    res_valid_q, res_valid_d;
   logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
   logic                    err_valid_q, err_valid_d;
   err_e                    err_code_q, err_code_d;
   op_e                     tok_op;
   logic [DATA_WIDTH-1:0]   alu_y;

   // Flags are only a cross-check for the shadow count and deliberately unused here.
   logic unused_flags;
   assign unused_flags = stk_full ^ stk_empty;

   assign tok_op    = op_e'(tok_data[OP_FIELD_W-1:0]);
   assign tok_ready = (state_q == StIdle);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign depth     = depth_q;

   rpn_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .a  (stk_top),
      .b  (b_q),
      .op (op_q),
      .y  (alu_y)
   );

   always_comb begin
      state_d     = state_q;
      depth_d     = depth_q;
      b_d         = b_q;
      op_d        = op_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      err_valid_d = 1'b0;
      err_code_d  = ErrNone;
      stk_insert  = 1'b0;
      stk_pop     = 1'b0;
      stk_entry   = '0;
      unique case (state_q)
         StIdle: begin
            if (tok_valid) begin
               if (!tok_is_op || tok_op == OpDup) begin
                  if (depth_q < FULL_CNT) begin
                     stk_insert = 1'b1;
                     stk_entry  = tok_is_op ? stk_top : tok_data;
                     depth_d    = depth_q + ONE;
                  end else begin
                     err_valid_d = 1'b1;
                     err_code_d  = ErrOver;
                  end
               end else if (tok_op == OpEmit) begin
                  if (depth_q >= ONE) begin
                     stk_pop     = 1'b1;
                     res_data_d  = stk_top;
                     res_valid_d = 1'b1;
                     depth_d     = depth_q - ONE;
                     state_d     = StEmit;
                  end else begin
                     err_valid_d = 1'b1;
                     err_code_d  = ErrUnder;
                  end
               end else if (depth_q >= TWO) begin
                  // Pop B now; A surfaces as stk_top in the replace cycle.
                  stk_pop = 1'b1;
                  b_d     = stk_top;
                  op_d    = tok_op;
                  depth_d = depth_q - ONE;
                  state_d = StReplace;
               end else begin
                  err_valid_d = 1'b1;
                  err_code_d  = ErrUnder;
               end
            end
         end
         StReplace: begin
            stk_insert = 1'b1;
            stk_pop    = 1'b1;
            stk_entry  = alu_y;
            state_d    = StIdle;
         end
         StEmit: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // The stack shares this reset; keep strobes quiet while it is held.
      if (!rst_n) begin
         stk_insert = 1'b0;
         stk_pop    = 1'b0;
         stk_entry  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         depth_q     <= '0;
         b_q         <= '0;
         op_q        <= OpAdd;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ErrNone;
      end else begin
         state_q     <= state_d;
         depth_q     <= depth_d;
         b_q         <= b_d;
         op_q        <= op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

endmodule
